// File: rtl/seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux
//
// Time-multiplexes a 32-bit active-low four-digit seven-segment pattern word
// onto a common-anode display (shared segment bus + four digit enables).
// Incoming words are double-buffered (pend -> shadow) and only committed on
// the frame boundary, so a frame never mixes old and new patterns.
//
// Optional feature macro: SEG7_SCAN_GHOST_BLANK_EN
//   defined   : a BLANK phase of BLANK_CYCLES precedes every digit's DRIVE
//   undefined : DRIVE phases abut directly, no blank logic is built
//
// Parameters:
//   REFRESH_DIV   drive cycles per digit (2..65535)
//   BLANK_CYCLES  blank cycles before each digit (1..65535), blanking builds
//
// Ports:
//   CLOCK       in   1   single clock, rising edge
//   RESET       in   1   asynchronous active-high reset
//   pat_in      in  32   pattern word, byte n = digit n, bits {a..g,dp}
//   pat_valid   in   1   one-cycle capture strobe for pat_in
//   seg_n       out  8   active-low segment bus (registered)
//   an_n        out  4   active-low digit enables (registered, one-hot-low)
//   frame_done  out  1   pulse on the last drive cycle of digit 0
// ---------------------------------------------------------------------------
module seg7_scan_mux #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] pat_in,
    input  logic        pat_valid,
    output logic [7:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    localparam logic [0:0]  PH_DRIVE   = 1'b1;
    localparam logic [15:0] DRIVE_LAST = 16'(REFRESH_DIV - 1);

`ifdef SEG7_SCAN_GHOST_BLANK_EN
    localparam logic [0:0]  PH_BLANK   = 1'b0;
    localparam logic [0:0]  PH_RESET   = PH_BLANK;
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
`else
    localparam logic [0:0]  PH_RESET   = PH_DRIVE;
`endif

    // An out-of-range parameter set keeps the scan parked with the display
    // dark instead of producing a malformed refresh pattern.
    localparam logic CFG_OK = (REFRESH_DIV  >= 2) && (REFRESH_DIV  <= 65535) &&
                              (BLANK_CYCLES >= 1) && (BLANK_CYCLES <= 65535);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        run_q,       run_d;
    logic [0:0]  phase_q,     phase_d;
    logic [1:0]  dig_q,       dig_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [31:0] pend_q,      pend_d;
    logic        pend_flag_q, pend_flag_d;
    logic [31:0] shadow_q,    shadow_d;

    logic [7:0]  seg_n_q,     seg_n_d;
    logic [3:0]  an_n_q,      an_n_d;
    logic        frame_done_q, frame_done_d;

    logic        at_boundary;

    // ------------------------------------------------------------------
    // Scan sequencing, capture and commit.
    // The *_q state describes the cycle currently on the pins. run_q is
    // clear only for the first edge after reset: that edge loads the
    // outputs for the reset state instead of advancing, so the first
    // visible cycle is cycle 0 of digit 3 and the first frame is full
    // length.
    // ------------------------------------------------------------------
    always_comb begin
        run_d       = run_q;
        phase_d     = phase_q;
        dig_d       = dig_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        shadow_d    = shadow_q;

        // The edge ending the last drive cycle of digit 0.
        at_boundary = run_q && (phase_q == PH_DRIVE) && (dig_q == 2'd0) &&
                      (cnt_q == DRIVE_LAST);

        if (!run_q) begin
            run_d = CFG_OK;
        end else begin
            if (phase_q == PH_DRIVE) begin
                if (cnt_q == DRIVE_LAST) begin
                    cnt_d = 16'd0;
                    // 3 -> 2 -> 1 -> 0 -> 3 by natural 2-bit wrap.
                    dig_d = dig_q - 2'd1;
`ifdef SEG7_SCAN_GHOST_BLANK_EN
                    phase_d = PH_BLANK;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef SEG7_SCAN_GHOST_BLANK_EN
            else begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = 16'd0;
                    phase_d = PH_DRIVE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
        end

        // Latest strobe always wins the pending slot.
        if (pat_valid) begin
            pend_d      = pat_in;
            pend_flag_d = 1'b1;
        end

        // A strobe landing on the boundary edge bypasses pend so it is
        // shown in the very next frame; commit clears the pending flag
        // even when that same-edge strobe would otherwise set it.
        if (at_boundary && (pend_flag_q || pat_valid)) begin
            shadow_d    = pat_valid ? pat_in : pend_q;
            pend_flag_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next state so the registered pins line up
    // with the state of the cycle they belong to.
    // ------------------------------------------------------------------
    logic [7:0] shadow_byte [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign shadow_byte[gi] = shadow_d[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        seg_n_d      = 8'hFF;
        an_n_d       = 4'hF;
        frame_done_d = 1'b0;
        if (run_d && (phase_d == PH_DRIVE)) begin
            seg_n_d      = shadow_byte[dig_d];
            an_n_d       = ~(4'b0001 << dig_d);
            frame_done_d = (dig_d == 2'd0) && (cnt_d == DRIVE_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            run_q        <= 1'b0;
            phase_q      <= PH_RESET;
            dig_q        <= 2'd3;
            cnt_q        <= 16'd0;
            pend_q       <= 32'd0;
            pend_flag_q  <= 1'b0;
            shadow_q     <= 32'hFFFF_FFFF;
            seg_n_q      <= 8'hFF;
            an_n_q       <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            run_q        <= run_d;
            phase_q      <= phase_d;
            dig_q        <= dig_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_flag_q  <= pend_flag_d;
            shadow_q     <= shadow_d;
            seg_n_q      <= seg_n_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;

endmodule
